// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and constants for the MIPS data-memory responder:
//   - dmem_state_t : responder FSM states (IDLE, WAIT, RESP)
//   - WORD_BYTES   : bytes per word; the word index starts above these bits
//   - FAULT_*      : bit positions of the individual fault causes
//   - fault_causes : decodes the fault causes of a raw request
// -----------------------------------------------------------------------------
package mips_mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int WORD_LSB   = $clog2(WORD_BYTES);
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Fault cause bit positions inside fault_t.
  localparam int FAULT_MISALIGN = 0;  // addr[1:0] != 0
  localparam int FAULT_RANGE    = 1;  // address bit set above the word index
  localparam int FAULT_CONFLICT = 2;  // MemRead and MemWrite both high
  localparam int FAULT_W        = 3;

  typedef logic [FAULT_W-1:0] fault_t;

  // idx_w is the number of word-index bits; everything at or above
  // bit idx_w+WORD_LSB must be zero for an in-range access.
  function automatic fault_t fault_causes(input logic [ADDR_W-1:0] addr,
                                          input logic              mem_read,
                                          input logic              mem_write,
                                          input int                idx_w);
    fault_t f;
    f                 = '0;
    f[FAULT_MISALIGN] = |addr[WORD_LSB-1:0];
    f[FAULT_RANGE]    = (addr >> (idx_w + WORD_LSB)) != '0;
    f[FAULT_CONFLICT] = mem_read & mem_write;
    return f;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// MEM-stage load/store bus between the pipelined core and the data-memory
// responder.
//   master (core)      : drives MemRead, MemWrite, addr, wd; sees rd, ready,
//                        stall, err
//   slave  (responder) : the reverse
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  import mips_mem_pkg::*;

  logic              MemRead;   // load request
  logic              MemWrite;  // store request
  logic [ADDR_W-1:0] addr;      // byte address
  logic [DATA_W-1:0] wd;        // store data
  logic [DATA_W-1:0] rd;        // load data, valid with ready
  logic              ready;     // one-cycle completion pulse
  logic              stall;     // hold request to the core
  logic              err;       // one-cycle fault pulse with ready

  modport master (
    output MemRead, MemWrite, addr, wd,
    input  rd, ready, stall, err
  );

  modport slave (
    input  MemRead, MemWrite, addr, wd,
    output rd, ready, stall, err
  );

endinterface

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Synchronous single-port word RAM. One access per enabled cycle: a write
// when we=1, otherwise a read whose data appears on rdata after the edge and
// holds until the next enabled read.
//   clk   : clock, rising edge
//   en    : access enable
//   we    : 1 = write wdata to mem[idx], 0 = read mem[idx]
//   idx   : word index
//   wdata : write data
//   rdata : registered read data
// -----------------------------------------------------------------------------
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: storage has no reset; contents are undefined until written, and a
  // reset branch here would stop the array mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[idx] <= wdata;
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle data-memory responder for the MEM stage. A request seen in IDLE
// is latched, WAIT_CYCLES wait states are inserted, the access is performed
// on the internal word array on the edge entering RESP, and ready (plus err
// on a faulted access) pulses for the single RESP cycle.
//   clk : clock, rising edge
//   rst : asynchronous reset, active low
//   bus : dmem_responder_if.slave (MemRead, MemWrite, addr, wd -> rd, ready,
//         stall, err)
// Parameters: DEPTH_WORDS (power of two, >= 4), WAIT_CYCLES (0..15).
// -----------------------------------------------------------------------------
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  // Registered state and latched request.
  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              fault_q, fault_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  // Selects RAM read data onto rd; cleared for writes, faults and reset so
  // rd reads as zero there without resetting the RAM output register.
  logic              rd_sel_q, rd_sel_d;

  // Access performed on this edge (either from the latch or, with no wait
  // states, straight from the bus).
  logic              acc_go;
  logic              acc_wr;
  logic              acc_fault;
  logic [IDX_W-1:0]  acc_idx;
  logic [DATA_W-1:0] acc_wd;

  logic              req;
  logic              fault_now;
  logic              ram_en;
  logic [DATA_W-1:0] ram_rdata;

  assign req       = bus.MemRead | bus.MemWrite;
  assign fault_now = |fault_causes(bus.addr, bus.MemRead, bus.MemWrite, IDX_W);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred; always_comb uses blocking '='.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    fault_d   = fault_q;
    idx_d     = idx_q;
    wd_d      = wd_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    rd_sel_d  = rd_sel_q;
    acc_go    = 1'b0;
    acc_wr    = wr_q;
    acc_fault = fault_q;
    acc_idx   = idx_q;
    acc_wd    = wd_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = bus.MemWrite;
          fault_d = fault_now;
          idx_d   = bus.addr[IDX_W+WORD_LSB-1:WORD_LSB];
          wd_d    = bus.wd;
          if (WAIT_CYCLES == 0) begin
            state_d   = RESP;
            acc_go    = 1'b1;
            acc_wr    = bus.MemWrite;
            acc_fault = fault_now;
            acc_idx   = bus.addr[IDX_W+WORD_LSB-1:WORD_LSB];
            acc_wd    = bus.wd;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        // Exit is taken at zero, so the counter never wraps.
        if (cnt_q == '0) begin
          state_d = RESP;
          acc_go  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (acc_go) begin
      ready_d  = 1'b1;
      err_d    = acc_fault;
      rd_sel_d = ~acc_fault & ~acc_wr;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      fault_q  <= 1'b0;
      idx_q    <= '0;
      wd_q     <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      fault_q  <= fault_d;
      idx_q    <= idx_d;
      wd_q     <= wd_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  // Faulted accesses never touch the array; gating with rst keeps a request
  // held on the bus during reset from writing the unreset RAM.
  assign ram_en = acc_go & ~acc_fault & rst;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (acc_wr),
    .idx   (acc_idx),
    .wdata (acc_wd),
    .rdata (ram_rdata)
  );

  assign bus.stall = ((state_q == IDLE) & req) | (state_q == WAIT);
  assign bus.rd    = rd_sel_q ? ram_rdata : '0;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving the MEM-stage load/store port of the pipelined MIPS core. The core issues word-wide read/write requests; this block latches each request, inserts a programmable number of wait states, performs the access on an internal word array, and returns read data with a one-cycle `ready` pulse. `stall` tells the core to freeze its PC and pipeline registers until the access completes.

## Interface
- `DEPTH_WORDS`, 256: words of storage; power of two, ≥ 4.
- `WAIT_CYCLES`, 2: wait states between acceptance and response; 0..15.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `MemRead`  in  1  load request from MEM stage.
- `MemWrite`  in  1  store request from MEM stage.
- `addr`  in  32  byte address.
- `wd`  in  32  store data.
- `rd`  out  32  load data; valid when `ready`=1.
- `ready`  out  1  one-cycle completion pulse.
- `stall`  out  1  combinational hold request to the core.
- `err`  out  1  one-cycle pulse with `ready` on a faulted access.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if `MemRead|MemWrite`, latch `addr`, `wd`, and request type, then go to WAIT. If `WAIT_CYCLES`=0, go directly to RESP.
- WAIT: down-counter loaded with `WAIT_CYCLES-1` on acceptance. At count 0, perform the access and go to RESP.
- RESP: drive `ready`=1 (plus `err` if faulted), then return to IDLE unconditionally. New requests are never accepted in RESP.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`.
- Faults: `addr[1:0]`≠0, any `addr` bit above the index range set, or `MemRead&MemWrite` both high. On a fault:
  - no array write occurs;
  - `rd`=0;
  - `err`=1 in RESP.
- Read: `rd` is registered with `mem[idx]` on the WAIT→RESP (or IDLE→RESP) edge. It holds that value until the next response.
- Write: `mem[idx]`←`wd` is committed on that same edge. A read of the same word issued afterward returns the new value.
- `stall` = (IDLE & (`MemRead|MemWrite`)) | WAIT. It is 0 in RESP so the core advances on the `ready` cycle.
- Requests are sampled only in IDLE. Input changes during WAIT/RESP are ignored.
- The storage array is not reset. Its contents are undefined until written.

## Timing
- Reset values: state=IDLE, counter=0, `rd`=0, `ready`=0, `err`=0. `stall` is then a function of the inputs.
- A request present in IDLE at edge N produces `ready` high during cycle N+`WAIT_CYCLES`+1.
- Back-to-back requests: after a RESP cycle there is one IDLE cycle, which accepts the next request at its edge. Throughput is one access per `WAIT_CYCLES`+2 cycles.
- Reset asserted mid-access (WAIT or RESP): return to IDLE immediately. A pending write is discarded. `ready`/`err` go low at once.
- Counter width is 4 bits. It never wraps below 0, because the exit is taken at 0.

## Structure
- Shared package `mips_mem_pkg`:
  - state enum `dmem_state_t` {IDLE, WAIT, RESP};
  - constant `WORD_BYTES`=4;
  - fault-cause localparams.
- Sub-module `dmem_array`: synchronous single-port word RAM, one write or read per cycle, no reset. The FSM, counter and fault checking stay in the top.

## Test plan
- Reset: hold `rst`=0 with `MemRead`=1, then release → `ready`=0, `rd`=0; `stall`=1 in the first IDLE cycle.
- Store `addr`=0x10, `wd`=0xDEADBEEF; then load 0x10 (`WAIT_CYCLES`=2) → `ready` 3 cycles after each acceptance; load returns `rd`=0xDEADBEEF; `stall` high for exactly 3 cycles per access.
- `WAIT_CYCLES`=0 with back-to-back loads of 0x0 and 0x4 → `ready` at N+1 and N+3; one IDLE gap between them.
- Misaligned load 0x13, out-of-range store 0x400 (`DEPTH_WORDS`=256), and `MemRead`=`MemWrite`=1 → `err`=`ready`=1, `rd`=0; a follow-up read of word 0 is unchanged.
- Store 0x20←0x12345678, then reset asserted during WAIT, then load 0x20 → returns the pre-existing value, not 0x12345678; the FSM is in IDLE the cycle after reset deassertion.
